// File: rtl/astro_pkg.sv
// Shared types and constants for the window datapath: window layout, memory address width,
// the set-complete flag value and the window writer state encoding.
package astro_pkg;

    localparam int WIN_DIM       = 16;
    localparam int ADDR_W        = 21;
    localparam int WORDS_PER_ROW = WIN_DIM / 4;
    localparam int ROW_W         = $clog2(WIN_DIM);
    localparam int QUAD_W        = $clog2(WORDS_PER_ROW);

    localparam logic [31:0] FLAG_SET_DONE = 32'h0000_0004;

    // [row][col] byte
    typedef logic [WIN_DIM-1:0][WIN_DIM-1:0][7:0] window_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FLAG,
        DONE
    } writer_state_t;

endpackage

// File: rtl/window_word_mux.sv
// Selects one packed 32-bit memory word from a window: four consecutive bytes of one row,
// the lowest column landing in the most significant byte.
module window_word_mux
    import astro_pkg::*;
(
    input  window_t           win,
    input  logic [ROW_W-1:0]  row,
    input  logic [QUAD_W-1:0] quad,
    output logic [31:0]       word
);

    assign word = {win[row][{quad, 2'd0}],
                   win[row][{quad, 2'd1}],
                   win[row][{quad, 2'd2}],
                   win[row][{quad, 2'd3}]};

endmodule

// File: rtl/window_writer.sv
// Captures a 16x16 byte window, streams it to memory as 64 packed words over the FPGA write
// port with a ready handshake, then strobes the set-complete flag and pulses done.
module window_writer #(
    parameter int          WIN_DIM    = astro_pkg::WIN_DIM,
    parameter int          ADDR_W     = astro_pkg::ADDR_W,
    parameter int          ROW_STRIDE = 4,
    parameter logic [31:0] DONE_FLAG  = astro_pkg::FLAG_SET_DONE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  astro_pkg::window_t  window_data,
    input  logic                window_valid,
    output logic                window_ack,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic                FPGA_wr_en,
    output logic [ADDR_W-1:0]   req_addr,
    output logic [31:0]         write_data,
    input  logic                wr_ready,
    output logic                flag_we,
    output logic [31:0]         out_flag,
    output logic                busy,
    output logic                done
);

    import astro_pkg::*;

    localparam int WPR = WIN_DIM / 4;

    writer_state_t     state_q;
    writer_state_t     state_d;
    window_t           win_q;
    logic [ADDR_W-1:0] row_addr_q;
    logic [ROW_W-1:0]  row_q;
    logic [QUAD_W-1:0] quad_q;
    logic [31:0]       mux_word;
    logic              accept;
    logic              last_quad;
    logic              last_word;

    assign accept    = (state_q == WRITE) & wr_ready;
    assign last_quad = (quad_q == QUAD_W'(WPR - 1));
    assign last_word = last_quad & (row_q == ROW_W'(WIN_DIM - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (window_ack) state_d = WRITE;
            WRITE:   if (accept && last_word) state_d = FLAG;
            FLAG:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        window_ack = 1'b0;
        FPGA_wr_en = 1'b0;
        req_addr   = '0;
        write_data = '0;
        flag_we    = 1'b0;
        out_flag   = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst_n so nothing is acknowledged while reset is held.
                window_ack = window_valid & rst_n;
            end
            WRITE: begin
                FPGA_wr_en = 1'b1;
                req_addr   = row_addr_q + ADDR_W'(quad_q);
                write_data = mux_word;
                busy       = 1'b1;
            end
            FLAG: begin
                flag_we  = 1'b1;
                out_flag = DONE_FLAG;
                busy     = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    // Row base address accumulates the stride instead of multiplying; wraps at 2^ADDR_W.
    // NOTE: the captured window copy is reset too, so no stale pixels survive a reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q      <= '0;
            row_addr_q <= '0;
            row_q      <= '0;
            quad_q     <= '0;
        end else if (window_ack) begin
            win_q      <= window_data;
            row_addr_q <= base_addr;
            row_q      <= '0;
            quad_q     <= '0;
        end else if (accept) begin
            if (last_quad) begin
                quad_q     <= '0;
                row_q      <= row_q + 1'b1;
                row_addr_q <= row_addr_q + ADDR_W'(ROW_STRIDE);
            end else begin
                quad_q <= quad_q + 1'b1;
            end
        end
    end

    window_word_mux u_word_mux (
        .win  (win_q),
        .row  (row_q),
        .quad (quad_q),
        .word (mux_word)
    );

endmodule
